// File: rtl/psum_pkg.sv
// Shared widths, FSM encoding and the saturating accumulate used by psum_accum_requant.
package psum_pkg;

  localparam int PSUM_W  = 10;
  localparam int ACC_W   = 18;
  localparam int OUT_W   = 4;
  localparam int BIAS_W  = 12;
  localparam int SHIFT_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  typedef struct packed {
    logic                    ovf;
    logic signed [ACC_W-1:0] sum;
  } sat_sum_t;

  // One guard bit is enough: a psum is far narrower than the accumulator.
  function automatic sat_sum_t sat_add(input logic signed [ACC_W-1:0]  a,
                                       input logic signed [PSUM_W-1:0] b);
    logic signed [ACC_W:0] wide;
    sat_sum_t              res;
    wide    = {a[ACC_W-1], a} + {{(ACC_W+1-PSUM_W){b[PSUM_W-1]}}, b};
    res.ovf = wide[ACC_W] ^ wide[ACC_W-1];
    if (res.ovf) begin
      res.sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      res.sum = wide[ACC_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/requant_relu_sat.sv
// Output stage: ReLU, right shift (round-half-up when PSUM_ROUND_EN is defined), clamp, register.
// One cycle from sum to registered activation; act/sat hold between valid pulses.
module requant_relu_sat
  import psum_pkg::*;
#(
  parameter int Acc_Width   = ACC_W,
  parameter int Out_Width   = OUT_W,
  parameter int Shift_Width = SHIFT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sum_valid,
  input  logic signed [Acc_Width:0] sum,
  input  logic [Shift_Width-1:0] shift,
  input  logic                   acc_sat,
  output logic                   act_valid,
  output logic [Out_Width-1:0]   act,
  output logic                   sat
);

  localparam int EW = Acc_Width + 2;

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] shifted;
  logic [EW-1:0]        r;
  logic                 big;

`ifdef PSUM_ROUND_EN
  logic signed [EW-1:0] half;
  assign half = (shift == '0) ? '0 : (EW'(1) <<< (shift - 1'b1));
  assign ext  = {sum[Acc_Width], sum} + half;
`else
  assign ext  = {sum[Acc_Width], sum};
`endif

  // A non-negative value shifted by its full width or more naturally yields 0.
  assign shifted = ext >>> shift;
  assign r       = sum[Acc_Width] ? '0 : shifted;
  assign big     = |r[EW-1:Out_Width];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_valid <= 1'b0;
      act       <= '0;
      sat       <= 1'b0;
    end else begin
      act_valid <= sum_valid;
      if (sum_valid) begin
        act <= big ? {Out_Width{1'b1}} : r[Out_Width-1:0];
        sat <= acc_sat | big;
      end
    end
  end

endmodule

// File: rtl/psum_accum_requant.sv
// Accumulates MAC-tree partial sums per pixel, adds bias, then requantizes to a 4-bit activation.
// Optional PSUM_ROUND_EN selects round-half-up instead of truncation in the output stage.
module psum_accum_requant
  import psum_pkg::*;
#(
  parameter int Psum_Width  = PSUM_W,
  parameter int Acc_Width   = ACC_W,
  parameter int Bias_Width  = BIAS_W,
  parameter int Out_Width   = OUT_W,
  parameter int Shift_Width = SHIFT_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_valid,
  input  logic                          i_first,
  input  logic                          i_last,
  input  logic signed [Psum_Width-1:0]  i_psum,
  input  logic signed [Bias_Width-1:0]  i_bias,
  input  logic [Shift_Width-1:0]        i_shift,
  input  logic                          i_clr_err,
  output logic                          o_valid,
  output logic [Out_Width-1:0]          o_act,
  output logic                          o_sat,
  output logic                          o_err_seq
);

  state_t                        state, state_nxt;
  logic signed [Acc_Width-1:0]   acc, acc_nxt;
  logic                          acc_sat, acc_sat_nxt;
  logic                          err_set;
  sat_sum_t                      add;

  logic                          fin_valid;
  logic signed [Bias_Width-1:0]  bias_q;
  logic [Shift_Width-1:0]        shift_q;

  logic                          s1_valid;
  logic signed [Acc_Width:0]     s1_sum;
  logic [Shift_Width-1:0]        s1_shift;
  logic                          s1_sat;

  assign add = sat_add(acc, i_psum);

  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    acc_sat_nxt = acc_sat;
    err_set     = 1'b0;
    if (i_valid) begin
      // A stray non-first beat in IDLE or a first beat inside ACCUM both restart the pixel.
      err_set = (state == IDLE) ? !i_first : i_first;
      if (state == IDLE || i_first) begin
        acc_nxt     = {{(Acc_Width-Psum_Width){i_psum[Psum_Width-1]}}, i_psum};
        acc_sat_nxt = 1'b0;
      end else begin
        acc_nxt     = add.sum;
        acc_sat_nxt = acc_sat | add.ovf;
      end
      state_nxt = i_last ? IDLE : ACCUM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      acc_sat   <= 1'b0;
      o_err_seq <= 1'b0;
      fin_valid <= 1'b0;
      bias_q    <= '0;
      shift_q   <= '0;
      s1_valid  <= 1'b0;
      s1_sum    <= '0;
      s1_shift  <= '0;
      s1_sat    <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      acc_sat   <= acc_sat_nxt;
      o_err_seq <= err_set | (o_err_seq & ~i_clr_err);
      fin_valid <= i_valid & i_last;
      if (i_valid && i_last) begin
        bias_q  <= i_bias;
        shift_q <= i_shift;
      end
      // acc still holds the finished pixel here even if the next pixel's first beat lands now.
      s1_valid <= fin_valid;
      if (fin_valid) begin
        s1_sum   <= {acc[Acc_Width-1], acc}
                  + {{(Acc_Width+1-Bias_Width){bias_q[Bias_Width-1]}}, bias_q};
        s1_shift <= shift_q;
        s1_sat   <= acc_sat;
      end
    end
  end

  requant_relu_sat #(
    .Acc_Width   (Acc_Width),
    .Out_Width   (Out_Width),
    .Shift_Width (Shift_Width)
  ) u_requant (
    .clk       (clk),
    .rst       (rst),
    .sum_valid (s1_valid),
    .sum       (s1_sum),
    .shift     (s1_shift),
    .acc_sat   (s1_sat),
    .act_valid (o_valid),
    .act       (o_act),
    .sat       (o_sat)
  );

endmodule
